// File: rtl/game_screen_sequencer_pkg.sv
// game_seq_pkg: shared types and constants for the game screen sequencer.
//   state_e         : FSM state encoding (also exported on the debug port)
//   FRAMES_PER_SEC  : gameplay frames per countdown second
//   LFSR_SEED/TAPS  : snitch scheduler Galois LFSR configuration
//   SNITCH_MIN_GAP  : minimum frames between snitch windows
package game_seq_pkg;

  typedef enum logic [2:0] {
    S_LOGO    = 3'd0,
    S_READY   = 3'd1,
    S_PLAY    = 3'd2,
    S_TIMESUP = 3'd3,
    S_BOARD   = 3'd4
  } state_e;

  localparam int unsigned FRAMES_PER_SEC = 60;
  localparam logic [15:0] LFSR_SEED      = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam int unsigned SNITCH_MIN_GAP = 120;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Right-shifting Galois LFSR step.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/game_screen_sequencer_snitch.sv
// snitch_scheduler: randomised snitch power-up window during gameplay.
//   clk_i, rst_ni     : pixel clock, async active-low reset
//   frame_tick_i      : one pulse per frame
//   play_i            : gameplay state in effect from the next clock
//   snitch_caught_i   : one-cycle catch pulse, closes an open window
//   snitch_powerup_o  : window active
// Only built when SNITCH_POWERUP_EN is defined.
module snitch_scheduler
  import game_seq_pkg::*;
#(
  parameter int unsigned SNITCH_FRAMES = 300
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic frame_tick_i,
  input  logic play_i,
  input  logic snitch_caught_i,
  output logic snitch_powerup_o
);

  localparam logic [11:0] WIN_W = 12'(SNITCH_FRAMES);

  logic [15:0] lfsr_q, lfsr_d;
  logic        play_prev_q;
  logic [8:0]  gap_q, gap_d;
  logic        win_q, win_d;
  logic [11:0] wcnt_q, wcnt_d;
  logic [8:0]  gap_load;

  always_comb begin
    lfsr_d   = lfsr_next(lfsr_q);
    gap_load = 9'(SNITCH_MIN_GAP) + {1'b0, lfsr_q[7:0]};
    gap_d    = gap_q;
    win_d    = win_q;
    wcnt_d   = wcnt_q;
    // play_i is the next-state view, so the window closes on the same
    // edge that play_active falls and the entry tick is not counted.
    if (!play_i) begin
      win_d = 1'b0;
    end else if (!play_prev_q) begin
      gap_d = gap_load;
      win_d = 1'b0;
    end else if (win_q) begin
      if (snitch_caught_i) begin
        win_d = 1'b0;
        gap_d = gap_load;
      end else if (frame_tick_i) begin
        if (wcnt_q <= 12'd1) begin
          win_d = 1'b0;
          gap_d = gap_load;
        end else begin
          wcnt_d = wcnt_q - 12'd1;
        end
      end
    end else if (frame_tick_i) begin
      if (gap_q <= 9'd1) begin
        win_d  = 1'b1;
        wcnt_d = WIN_W;
      end else begin
        gap_d = gap_q - 9'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q      <= LFSR_SEED;
      play_prev_q <= 1'b0;
      gap_q       <= '0;
      win_q       <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      play_prev_q <= play_i;
      gap_q       <= gap_d;
      win_q       <= win_d;
      wcnt_q      <= wcnt_d;
    end
  end

  assign snitch_powerup_o = win_q;

endmodule

// File: rtl/game_screen_sequencer.sv
// game_screen_sequencer: frame-synchronous game flow controller.
// Steps logo -> get-ready -> play -> times-up -> leaderboard -> logo,
// changing screens only on frame ticks derived from iVS falling edges.
//   iVGA_CLK, iRST_n    : pixel clock, async active-low reset
//   iVS                 : active-low vertical sync
//   start_btn           : start/skip level (rising edges only)
//   two_player_req      : mode request, latched when leaving logo
//   house1, house2      : one-hot house selects
//   snitch_caught       : catch pulse
//   logo/get_ready/times_up/leaderboard/play_active : screen flags
//   two_player_mode, seconds_left, frame_tick, snitch_powerup, state
// Optional feature macro: SNITCH_POWERUP_EN (snitch window scheduling).
module game_screen_sequencer
  import game_seq_pkg::*;
#(
  parameter int unsigned LOGO_MIN_FRAMES = 60,
  parameter int unsigned READY_FRAMES    = 180,
  parameter int unsigned PLAY_SECONDS    = 60,
  parameter int unsigned TIMESUP_FRAMES  = 120,
  parameter int unsigned BOARD_FRAMES    = 600,
  parameter int unsigned SNITCH_FRAMES   = 300
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       iVS,
  input  logic       start_btn,
  input  logic       two_player_req,
  input  logic [3:0] house1,
  input  logic [3:0] house2,
  input  logic       snitch_caught,
  output logic       logo,
  output logic       get_ready,
  output logic       times_up,
  output logic       leaderboard,
  output logic       play_active,
  output logic       two_player_mode,
  output logic [7:0] seconds_left,
  output logic       frame_tick,
  output logic       snitch_powerup,
  output logic [2:0] state
);

  localparam logic [11:0] LOGO_MIN_W = 12'(LOGO_MIN_FRAMES);
  localparam logic [11:0] READY_W    = 12'(READY_FRAMES);
  localparam logic [11:0] TIMESUP_W  = 12'(TIMESUP_FRAMES);
  localparam logic [11:0] BOARD_W    = 12'(BOARD_FRAMES);
  localparam logic [7:0]  PLAY_W     = 8'(PLAY_SECONDS);
  localparam logic [5:0]  LAST_SUB   = 6'(FRAMES_PER_SEC - 1);

  state_e      state_q, state_d;
  logic        vs_prev_q, ft_q;
  logic        btn_prev_q;
  logic        pend_q, pend_d;
  logic [11:0] fcnt_q, fcnt_d;
  logic [5:0]  sub_q, sub_d;
  logic [7:0]  sec_q, sec_d;
  logic        tpm_q, tpm_d;
  logic        logo_q, ready_q, play_q, tu_q, board_q;
  logic        start_edge, start_now, house_ok;

  always_comb begin
    start_edge = start_btn & ~btn_prev_q;
    // An edge on the tick cycle itself still counts for that tick.
    start_now  = pend_q | (start_edge & ((state_q == S_LOGO) || (state_q == S_BOARD)));
    pend_d     = ft_q ? 1'b0 : start_now;
    house_ok   = is_onehot4(house1) && (!two_player_req || is_onehot4(house2));
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    sub_d      = sub_q;
    sec_d      = sec_q;
    tpm_d      = tpm_q;
    if (ft_q) begin
      fcnt_d = (fcnt_q == 12'hFFF) ? fcnt_q : fcnt_q + 12'd1;
      case (state_q)
        S_LOGO: begin
          if ((fcnt_q >= LOGO_MIN_W) && start_now && house_ok) begin
            state_d = S_READY;
            tpm_d   = two_player_req;
          end
        end
        S_READY: begin
          if (fcnt_q + 12'd1 == READY_W) begin
            state_d = S_PLAY;
            sec_d   = PLAY_W;
            sub_d   = '0;
          end
        end
        S_PLAY: begin
          if (sub_q == LAST_SUB) begin
            sub_d = '0;
            if (sec_q <= 8'd1) begin
              state_d = S_TIMESUP;
              sec_d   = '0;
            end else begin
              sec_d = sec_q - 8'd1;
            end
          end else begin
            sub_d = sub_q + 6'd1;
          end
        end
        S_TIMESUP: begin
          if (fcnt_q + 12'd1 == TIMESUP_W) state_d = S_BOARD;
        end
        S_BOARD: begin
          if ((fcnt_q + 12'd1 == BOARD_W) || start_now) begin
            state_d = S_LOGO;
            tpm_d   = 1'b0;
          end
        end
        default: state_d = S_LOGO;
      endcase
      if (state_d != state_q) fcnt_d = '0;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= S_LOGO;
      vs_prev_q  <= 1'b1;
      ft_q       <= 1'b0;
      btn_prev_q <= 1'b0;
      pend_q     <= 1'b0;
      fcnt_q     <= '0;
      sub_q      <= '0;
      sec_q      <= '0;
      tpm_q      <= 1'b0;
      logo_q     <= 1'b1;
      ready_q    <= 1'b0;
      play_q     <= 1'b0;
      tu_q       <= 1'b0;
      board_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_prev_q  <= iVS;
      ft_q       <= vs_prev_q & ~iVS;
      btn_prev_q <= start_btn;
      pend_q     <= pend_d;
      fcnt_q     <= fcnt_d;
      sub_q      <= sub_d;
      sec_q      <= sec_d;
      tpm_q      <= tpm_d;
      logo_q     <= (state_d == S_LOGO);
      ready_q    <= (state_d == S_READY);
      play_q     <= (state_d == S_PLAY);
      tu_q       <= (state_d == S_TIMESUP);
      board_q    <= (state_d == S_BOARD);
    end
  end

  assign logo            = logo_q;
  assign get_ready       = ready_q;
  assign play_active     = play_q;
  assign times_up        = tu_q;
  assign leaderboard     = board_q;
  assign two_player_mode = tpm_q;
  assign seconds_left    = sec_q;
  assign frame_tick      = ft_q;
  assign state           = state_q;

`ifdef SNITCH_POWERUP_EN
  snitch_scheduler #(
    .SNITCH_FRAMES(SNITCH_FRAMES)
  ) u_snitch (
    .clk_i           (iVGA_CLK),
    .rst_ni          (iRST_n),
    .frame_tick_i    (ft_q),
    .play_i          (state_d == S_PLAY),
    .snitch_caught_i (snitch_caught),
    .snitch_powerup_o(snitch_powerup)
  );
`else
  logic unused_snitch;
  assign unused_snitch  = snitch_caught | (SNITCH_FRAMES == 0);
  assign snitch_powerup = 1'b0;
`endif

endmodule

// File: tb/tb_game_screen_sequencer.sv
module tb_game_screen_sequencer;
  import game_seq_pkg::*;

  localparam int unsigned VSP = 8;
`ifdef SNITCH_POWERUP_EN
  localparam int unsigned PS = 8;
`else
  localparam int unsigned PS = 2;
`endif

  logic       iVGA_CLK = 1'b0;
  logic       iRST_n, iVS, start_btn, two_player_req, snitch_caught;
  logic [3:0] house1, house2;
  logic       logo, get_ready, times_up, leaderboard, play_active;
  logic       two_player_mode, frame_tick, snitch_powerup;
  logic [7:0] seconds_left;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  logic [15:0] mdl_lfsr;
  logic [15:0] tick_lfsr = 16'h0;

  always #5 iVGA_CLK = ~iVGA_CLK;

  game_screen_sequencer #(
    .LOGO_MIN_FRAMES(2),
    .READY_FRAMES   (3),
    .PLAY_SECONDS   (PS),
    .TIMESUP_FRAMES (2),
    .BOARD_FRAMES   (4),
    .SNITCH_FRAMES  (5)
  ) dut (
    .iVGA_CLK       (iVGA_CLK),
    .iRST_n         (iRST_n),
    .iVS            (iVS),
    .start_btn      (start_btn),
    .two_player_req (two_player_req),
    .house1         (house1),
    .house2         (house2),
    .snitch_caught  (snitch_caught),
    .logo           (logo),
    .get_ready      (get_ready),
    .times_up       (times_up),
    .leaderboard    (leaderboard),
    .play_active    (play_active),
    .two_player_mode(two_player_mode),
    .seconds_left   (seconds_left),
    .frame_tick     (frame_tick),
    .snitch_powerup (snitch_powerup),
    .state          (state)
  );

  // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting, one step per clock.
  always @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) mdl_lfsr <= 16'hACE1;
    else         mdl_lfsr <= (mdl_lfsr >> 1) ^ (mdl_lfsr[0] ? 16'hB400 : 16'h0000);
  end

`ifndef SNITCH_POWERUP_EN
  logic saw_snitch = 1'b0;
  always @(negedge iVGA_CLK) if (snitch_powerup !== 1'b0) saw_snitch = 1'b1;
`endif

  function automatic logic [4:0] flags();
    return {logo, get_ready, play_active, times_up, leaderboard};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame: iVS low for one clock; frame_tick is high during the next
  // cycle, whose LFSR value is recorded; returns with that tick's results visible.
  task automatic frame();
    @(negedge iVGA_CLK) iVS = 1'b0;
    @(negedge iVGA_CLK) begin
      iVS = 1'b1;
      tick_lfsr = mdl_lfsr;
    end
    repeat (VSP - 2) @(negedge iVGA_CLK);
  endtask

  task automatic press();
    @(negedge iVGA_CLK) start_btn = 1'b1;
    @(negedge iVGA_CLK) start_btn = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge iVGA_CLK) iRST_n = 1'b0;
    repeat (3) @(negedge iVGA_CLK);
    iRST_n = 1'b1;
    repeat (2) @(negedge iVGA_CLK);
  endtask

  initial begin
    iRST_n = 1'b0; iVS = 1'b1; start_btn = 1'b0; two_player_req = 1'b0;
    house1 = 4'b0000; house2 = 4'b0000; snitch_caught = 1'b0;
    repeat (3) @(negedge iVGA_CLK);
    check("rst_flags", 16'(flags()), 16'b10000);
    check("rst_state", 16'(state), 16'd0);
    check("rst_sec", 16'(seconds_left), 16'd0);
    check("rst_misc", {13'd0, two_player_mode, frame_tick, snitch_powerup}, 16'd0);
    iRST_n = 1'b1;
    repeat (2) @(negedge iVGA_CLK);

    // frame_tick: one pulse, the cycle after iVS is seen low
    iVS = 1'b0;
    @(negedge iVGA_CLK) iVS = 1'b1;
    check("ftick_hi", 16'(frame_tick), 16'd1);
    @(negedge iVGA_CLK);
    check("ftick_lo", 16'(frame_tick), 16'd0);
    repeat (VSP) @(negedge iVGA_CLK);

    repeat (10) frame();
    check("idle_flags", 16'(flags()), 16'b10000);
    check("idle_state", 16'(state), 16'd0);
    check("idle_sec", 16'(seconds_left), 16'd0);

    // Start too early is discarded; start before tick 3 is honoured
    do_reset();
    house1 = 4'b0001;
    press(); frame();
    check("early_start", 16'(flags()), 16'b10000);
    frame();
    check("no_pend", 16'(flags()), 16'b10000);
    press(); frame();
    check("ready_flags", 16'(flags()), 16'b01000);
    check("ready_state", 16'(state), 16'd1);
    check("tpm_single", 16'(two_player_mode), 16'd0);
    frame(); frame();
    check("ready_hold", 16'(flags()), 16'b01000);
    frame();
    check("play_flags", 16'(flags()), 16'b00100);
    check("play_state", 16'(state), 16'd2);
    check("play_sec0", 16'(seconds_left), 16'(PS));

    repeat (59) frame();
    check("sec_t59", 16'(seconds_left), 16'(PS));
    frame();
    check("sec_t60", 16'(seconds_left), 16'(PS - 1));
    repeat (60 * PS - 61) frame();
    check("play_last", 16'(flags()), 16'b00100);
    check("sec_last", 16'(seconds_left), 16'd1);
    frame();
    check("tu_flags", 16'(flags()), 16'b00010);
    check("tu_state", 16'(state), 16'd3);
    check("tu_sec", 16'(seconds_left), 16'd0);
    frame();
    check("tu_hold", 16'(flags()), 16'b00010);
    frame();
    check("board_flags", 16'(flags()), 16'b00001);
    check("board_state", 16'(state), 16'd4);
    repeat (3) frame();
    check("board_hold", 16'(flags()), 16'b00001);
    frame();
    check("back_logo", 16'(flags()), 16'b10000);
    check("back_state", 16'(state), 16'd0);

    // Two-player: invalid house2 rejected, valid one accepted
    repeat (2) frame();
    two_player_req = 1'b1; house2 = 4'b0000;
    press(); frame();
    check("bad_house", 16'(flags()), 16'b10000);
    house2 = 4'b0010;
    press(); frame();
    check("tp_ready", 16'(flags()), 16'b01000);
    check("tp_mode", 16'(two_player_mode), 16'd1);
    repeat (3) frame();
    check("tp_play", 16'(flags()), 16'b00100);
    @(negedge iVGA_CLK) snitch_caught = 1'b1;
    @(negedge iVGA_CLK) snitch_caught = 1'b0;
    repeat (60) frame();
    check("tp_sec", 16'(seconds_left), 16'(PS - 1));

    // Asynchronous reset mid-play
    @(negedge iVGA_CLK) iRST_n = 1'b0;
    #1;
    check("mid_rst_flags", 16'(flags()), 16'b10000);
    check("mid_rst_sec", 16'(seconds_left), 16'd0);
    check("mid_rst_tpm", 16'(two_player_mode), 16'd0);
    check("mid_rst_state", 16'(state), 16'd0);
    @(negedge iVGA_CLK) iRST_n = 1'b1;
    two_player_req = 1'b0;
    repeat (2) @(negedge iVGA_CLK);

`ifdef SNITCH_POWERUP_EN
    begin
      int unsigned gap;
      repeat (2) frame();
      press(); frame();
      repeat (3) frame();
      check("sn_play", 16'(flags()), 16'b00100);
      gap = 120 + int'(tick_lfsr[7:0]);
      repeat (gap - 1) frame();
      check("sn_gap_lo", 16'(snitch_powerup), 16'd0);
      frame();
      check("sn_rise", 16'(snitch_powerup), 16'd1);
      snitch_caught = 1'b1;
      @(negedge iVGA_CLK) snitch_caught = 1'b0;
      check("sn_catch", 16'(snitch_powerup), 16'd0);
      check("sn_still_play", 16'(flags()), 16'b00100);
    end
`else
    check("sn_never", 16'(saw_snitch), 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
